// File: rtl/tb_mem_arbiter_if.sv
// Shared types for the test-bench memory port, and the requester-side bundle
// for the fetch and data ports of tb_mem_arbiter.
package pkg_cpu;
   typedef enum logic {
      cpu_data_acc_sz_8  = 1'b0,
      cpu_data_acc_sz_16 = 1'b1
   } cpu_data_acc_sz_t;

   // The memory clocks its writes from clk directly, so the bundle carries no clock.
   typedef struct packed {
      logic [15:0]      read_addr_in;
      cpu_data_acc_sz_t read_data_acc_sz;
      logic [15:0]      write_addr_in;
      cpu_data_acc_sz_t write_data_acc_sz;
      logic [15:0]      write_data_in;
      logic             write_data_we;
   } tb_mem_inputs;
endpackage

interface tb_mem_arbiter_if;
   logic                      ifetch_req;
   logic [15:0]               ifetch_addr;
   logic                      ifetch_wide;
   logic                      ifetch_ack;
   logic [31:0]               ifetch_data;
   logic                      dacc_req;
   logic                      dacc_we;
   pkg_cpu::cpu_data_acc_sz_t dacc_sz;
   logic [15:0]               dacc_addr;
   logic [15:0]               dacc_wdata;
   logic                      dacc_ack;
   logic [15:0]               dacc_rdata;

   modport master (
      output ifetch_req, ifetch_addr, ifetch_wide,
      input  ifetch_ack, ifetch_data,
      output dacc_req, dacc_we, dacc_sz, dacc_addr, dacc_wdata,
      input  dacc_ack, dacc_rdata
   );

   modport slave (
      input  ifetch_req, ifetch_addr, ifetch_wide,
      output ifetch_ack, ifetch_data,
      input  dacc_req, dacc_we, dacc_sz, dacc_addr, dacc_wdata,
      output dacc_ack, dacc_rdata
   );
endinterface

// File: rtl/tb_mem_arbiter.sv
// Round-robin arbiter between instruction fetch and data access in front of
// the single-port test-bench memory; wide fetches become two 16-bit reads.
//
//   state  | meaning
//   IDLE   | no access; arbitrate and latch a request
//   ACC_LO | first (or only) memory access; writes commit at its end
//   ACC_HI | second word of a wide fetch at addr + 2
//   DONE   | one-cycle ack to the owner; requests ignored
module tb_mem_arbiter #(
   parameter bit fetch_first = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   tb_mem_arbiter_if.slave       req_if,
   output pkg_cpu::tb_mem_inputs mem_out,
   input  logic [15:0]           mem_read_data,
   output logic                  busy
);
   import pkg_cpu::*;

   typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, DONE} state_t;

   state_t           state, state_nxt;
   logic             rr_ptr, ptr_nxt;
   logic             grant_fetch, grant_dacc;
   logic             own_fetch;
   logic [15:0]      l_addr;
   logic             l_wide;
   logic             l_we;
   cpu_data_acc_sz_t l_sz;
   logic [15:0]      l_wdata;
   logic [31:0]      ifetch_data;
   logic [15:0]      dacc_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         rr_ptr <= fetch_first;
      end else begin
         state  <= state_nxt;
         rr_ptr <= ptr_nxt;
      end
   end

   // rr_ptr = 1 favours fetch; it only moves when both sides ask at once.
   always_comb begin
      state_nxt   = state;
      ptr_nxt     = rr_ptr;
      grant_fetch = 1'b0;
      grant_dacc  = 1'b0;
      case (state)
         IDLE: begin
            if (req_if.ifetch_req && req_if.dacc_req) begin
               grant_fetch = rr_ptr;
               grant_dacc  = !rr_ptr;
               ptr_nxt     = !rr_ptr;
            end else begin
               grant_fetch = req_if.ifetch_req;
               grant_dacc  = req_if.dacc_req;
            end
            if (grant_fetch || grant_dacc)
               state_nxt = ACC_LO;
         end
         ACC_LO:  state_nxt = (own_fetch && l_wide) ? ACC_HI : DONE;
         ACC_HI:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         own_fetch <= 1'b0;
         l_addr    <= '0;
         l_wide    <= 1'b0;
         l_we      <= 1'b0;
         l_sz      <= cpu_data_acc_sz_8;
         l_wdata   <= '0;
      end else if (grant_fetch) begin
         own_fetch <= 1'b1;
         l_addr    <= req_if.ifetch_addr;
         l_wide    <= req_if.ifetch_wide;
         l_we      <= 1'b0;
         l_sz      <= cpu_data_acc_sz_16;
         l_wdata   <= '0;
      end else if (grant_dacc) begin
         own_fetch <= 1'b0;
         l_addr    <= req_if.dacc_addr;
         l_wide    <= 1'b0;
         l_we      <= req_if.dacc_we;
         l_sz      <= req_if.dacc_sz;
         l_wdata   <= req_if.dacc_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ifetch_data <= '0;
         dacc_rdata  <= '0;
      end else if (state == ACC_LO) begin
         if (own_fetch) begin
            if (l_wide)
               ifetch_data[31:16] <= mem_read_data;
            else
               ifetch_data <= {16'h0000, mem_read_data};
         end else if (!l_we) begin
            dacc_rdata <= mem_read_data;
         end
      end else if (state == ACC_HI) begin
         ifetch_data[15:0] <= mem_read_data;
      end
   end

   // Memory drive is purely decoded from state so reset silences it at once.
   always_comb begin
      mem_out = '0;
      case (state)
         ACC_LO: begin
            mem_out.read_addr_in      = l_addr;
            mem_out.write_addr_in     = l_addr;
            mem_out.read_data_acc_sz  = l_sz;
            mem_out.write_data_acc_sz = l_sz;
            mem_out.write_data_in     = l_wdata;
            mem_out.write_data_we     = !own_fetch && l_we;
         end
         ACC_HI: begin
            mem_out.read_addr_in      = l_addr + 16'd2;
            mem_out.write_addr_in     = l_addr + 16'd2;
            mem_out.read_data_acc_sz  = cpu_data_acc_sz_16;
            mem_out.write_data_acc_sz = cpu_data_acc_sz_16;
         end
         default: mem_out = '0;
      endcase
   end

   assign req_if.ifetch_ack  = (state == DONE) && own_fetch;
   assign req_if.dacc_ack    = (state == DONE) && !own_fetch;
   assign req_if.ifetch_data = ifetch_data;
   assign req_if.dacc_rdata  = dacc_rdata;
   assign busy               = (state != IDLE);
endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Directed bench for tb_mem_arbiter with a big-endian byte memory model
// (16-bit word at a = {mem[a], mem[a+1]}, 8-bit read zero-extended).
module tb_tb_mem_arbiter;
   import pkg_cpu::*;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   tb_mem_inputs mem_out;
   logic [15:0]  mem_read_data;
   logic         busy;
   int           n_checks = 0;
   int           n_fail = 0;

   logic [7:0]   mem [0:65535];
   logic         bd_we = 1'b0;
   logic [15:0]  bd_addr = '0;
   logic [7:0]   bd_data = '0;
   logic [15:0]  ra1, wa1;

   tb_mem_arbiter_if ifc();

   tb_mem_arbiter #(.fetch_first(1'b1)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_if        (ifc),
      .mem_out       (mem_out),
      .mem_read_data (mem_read_data),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   assign ra1 = mem_out.read_addr_in + 16'd1;
   assign wa1 = mem_out.write_addr_in + 16'd1;

   always_comb begin
      if (mem_out.read_data_acc_sz == cpu_data_acc_sz_16)
         mem_read_data = {mem[mem_out.read_addr_in], mem[ra1]};
      else
         mem_read_data = {8'h00, mem[mem_out.read_addr_in]};
   end

   always @(posedge clk) begin
      if (bd_we) begin
         mem[bd_addr] <= bd_data;
      end else if (mem_out.write_data_we) begin
         if (mem_out.write_data_acc_sz == cpu_data_acc_sz_16) begin
            mem[mem_out.write_addr_in] <= mem_out.write_data_in[15:8];
            mem[wa1]                   <= mem_out.write_data_in[7:0];
         end else begin
            mem[mem_out.write_addr_in] <= mem_out.write_data_in[7:0];
         end
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic poke(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic do_fetch(input logic [15:0] a, input logic wide, output int lat,
                           output logic [31:0] data, output logic we_seen,
                           output logic [15:0] addr_lo, output logic [15:0] addr_hi);
      @(negedge clk);
      ifc.ifetch_req = 1'b1; ifc.ifetch_addr = a; ifc.ifetch_wide = wide;
      lat = 0; data = '0; we_seen = 1'b0; addr_lo = '0; addr_hi = '0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         we_seen |= mem_out.write_data_we;
         if (k == 1) addr_lo = mem_out.read_addr_in;
         if (k == 2) addr_hi = mem_out.read_addr_in;
         if (ifc.ifetch_ack) begin
            lat = k; data = ifc.ifetch_data;
            break;
         end
      end
      ifc.ifetch_req = 1'b0;
   endtask

   task automatic do_dacc(input logic we, input cpu_data_acc_sz_t sz, input logic [15:0] a,
                          input logic [15:0] wd, output int lat, output logic [15:0] rd);
      @(negedge clk);
      ifc.dacc_req = 1'b1; ifc.dacc_we = we; ifc.dacc_sz = sz;
      ifc.dacc_addr = a; ifc.dacc_wdata = wd;
      lat = 0; rd = '0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (ifc.dacc_ack) begin
            lat = k; rd = ifc.dacc_rdata;
            break;
         end
      end
      ifc.dacc_req = 1'b0;
   endtask

   initial begin
      int          lat;
      logic [31:0] fd;
      logic [15:0] rd, alo, ahi;
      logic        we_seen, both_ack;
      int          f_cyc [2];
      int          d_cyc [2];
      int          nf, nd;

      ifc.ifetch_req = 1'b0; ifc.ifetch_addr = '0; ifc.ifetch_wide = 1'b0;
      ifc.dacc_req = 1'b0; ifc.dacc_we = 1'b0; ifc.dacc_sz = cpu_data_acc_sz_8;
      ifc.dacc_addr = '0; ifc.dacc_wdata = '0;

      poke(16'h0000, 8'h1E); poke(16'h0001, 8'h10);
      poke(16'h0010, 8'h12); poke(16'h0011, 8'h34);
      poke(16'h0012, 8'h56); poke(16'h0013, 8'h78);
      poke(16'h0200, 8'h11);
      check_val("rst_busy", busy, 0);
      check_val("rst_mem_out", mem_out, 0);
      check_val("rst_acks", {ifc.ifetch_ack, ifc.dacc_ack}, 0);
      check_val("rst_data", {ifc.ifetch_data, ifc.dacc_rdata}, 0);
      @(negedge clk); reset = 1'b1;

      // single 16-bit fetch
      do_fetch(16'h0000, 1'b0, lat, fd, we_seen, alo, ahi);
      check_val("f16_lat", lat, 2);
      check_val("f16_data", fd, 32'h0000_1E10);
      check_val("f16_no_we", we_seen, 0);
      @(negedge clk);
      check_val("f16_ack_pulse", ifc.ifetch_ack, 0);
      check_val("idle_busy", busy, 0);

      // wide fetch wrapping past 0xFFFF
      poke(16'hFFFE, 8'hAA); poke(16'hFFFF, 8'hAA);
      poke(16'h0000, 8'h55); poke(16'h0001, 8'h55);
      do_fetch(16'hFFFE, 1'b1, lat, fd, we_seen, alo, ahi);
      check_val("fw_lat", lat, 3);
      check_val("fw_data", fd, 32'hAAAA_5555);
      check_val("fw_addr_lo", alo, 16'hFFFE);
      check_val("fw_addr_hi", ahi, 16'h0000);

      do_fetch(16'h0010, 1'b1, lat, fd, we_seen, alo, ahi);
      check_val("fw2_data", fd, 32'h1234_5678);
      do_fetch(16'h0012, 1'b0, lat, fd, we_seen, alo, ahi);
      check_val("f16_clear_hi", fd, 32'h0000_5678);

      // data write then reads
      do_dacc(1'b1, cpu_data_acc_sz_16, 16'h0100, 16'hBEEF, lat, rd);
      check_val("dw_lat", lat, 2);
      check_val("dw_mem", {mem[16'h0100], mem[16'h0101]}, 16'hBEEF);
      do_dacc(1'b0, cpu_data_acc_sz_8, 16'h0101, 16'h0000, lat, rd);
      check_val("dr8_lat", lat, 2);
      check_val("dr8_data", rd, 16'h00EF);
      do_dacc(1'b1, cpu_data_acc_sz_8, 16'h0100, 16'h1255, lat, rd);
      do_dacc(1'b0, cpu_data_acc_sz_16, 16'h0100, 16'h0000, lat, rd);
      check_val("dr16_after_w8", rd, 16'h55EF);
      do_dacc(1'b0, cpu_data_acc_sz_16, 16'h0011, 16'h0000, lat, rd);
      check_val("dr16_unaligned", rd, 16'h3456);
      do_fetch(16'h0010, 1'b0, lat, fd, we_seen, alo, ahi);
      check_val("drdata_hold", ifc.dacc_rdata, 16'h3456);

      // contention from reset: F, D, F, D at cycles 2, 5, 8, 11
      @(negedge clk);
      reset = 1'b0;
      ifc.ifetch_req = 1'b1; ifc.ifetch_addr = 16'h0000; ifc.ifetch_wide = 1'b0;
      ifc.dacc_req = 1'b1; ifc.dacc_we = 1'b0; ifc.dacc_sz = cpu_data_acc_sz_16;
      ifc.dacc_addr = 16'h0100;
      @(negedge clk); reset = 1'b1;
      nf = 0; nd = 0; both_ack = 1'b0;
      f_cyc[0] = 0; f_cyc[1] = 0; d_cyc[0] = 0; d_cyc[1] = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (ifc.ifetch_ack && ifc.dacc_ack) both_ack = 1'b1;
         if (ifc.ifetch_ack && nf < 2) begin f_cyc[nf] = k; nf++; end
         if (ifc.dacc_ack && nd < 2) begin d_cyc[nd] = k; nd++; end
      end
      ifc.ifetch_req = 1'b0; ifc.dacc_req = 1'b0;
      check_val("rr_no_overlap", both_ack, 0);
      check_val("rr_f0", f_cyc[0], 2);
      check_val("rr_d0", d_cyc[0], 5);
      check_val("rr_f1", f_cyc[1], 8);
      check_val("rr_d1", d_cyc[1], 11);

      // reset in the middle of an 8-bit write
      @(negedge clk); @(negedge clk);
      ifc.dacc_req = 1'b1; ifc.dacc_we = 1'b1; ifc.dacc_sz = cpu_data_acc_sz_8;
      ifc.dacc_addr = 16'h0200; ifc.dacc_wdata = 16'h0077;
      @(negedge clk);
      check_val("mw_we_acc_lo", mem_out.write_data_we, 1);
      #1 reset = 1'b0;
      #1;
      check_val("mw_busy", busy, 0);
      check_val("mw_mem_out", mem_out, 0);
      check_val("mw_data", {ifc.ifetch_data, ifc.dacc_rdata}, 0);
      check_val("mw_acks", {ifc.ifetch_ack, ifc.dacc_ack}, 0);
      @(negedge clk);
      check_val("mw_not_committed", mem[16'h0200], 8'h11);
      ifc.dacc_we = 1'b0; ifc.dacc_addr = 16'h0100; ifc.dacc_sz = cpu_data_acc_sz_16;
      ifc.ifetch_req = 1'b1; ifc.ifetch_addr = 16'h0010; ifc.ifetch_wide = 1'b0;
      @(negedge clk); reset = 1'b1;
      lat = 0; both_ack = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (ifc.ifetch_ack || ifc.dacc_ack) begin
            lat = k; both_ack = ifc.ifetch_ack;
            break;
         end
      end
      ifc.ifetch_req = 1'b0; ifc.dacc_req = 1'b0;
      check_val("post_rst_lat", lat, 2);
      check_val("post_rst_fetch_first", both_ack, 1);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
